// File: rtl/anti_theft_timer.sv
// ---------------------------------------------------------------------------
// anti_theft_timer
//
// Timebase and countdown timer for anti_theft_fsm. It produces a free-running
// one-second strobe and, on request, counts a number of whole seconds down
// to zero. When it reaches zero it emits a single-cycle expiry pulse.
//
// Ports
//   clk            in   1        system clock, rising edge
//   rst            in   1        asynchronous active-low reset
//   start_timer    in   1        load request, sampled each rising edge
//   timer_value    in   VALUE_W  seconds to count, captured with start_timer
//   one_hz_enable  out  1        one-cycle strobe every TICK_DIV cycles
//   timer_expired  out  1        one-cycle pulse when the countdown ends
//   time_left      out  VALUE_W  remaining whole seconds
//   busy           out  1        high while counting
//
// Handshake: start_timer is a single-cycle command with no ready. It is
// accepted on every rising edge where it is high, in every state, and it
// always overrides the current countdown.
// ---------------------------------------------------------------------------
module anti_theft_timer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_DIV    = CLK_FREQ_HZ,
  parameter int VALUE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_timer,
  input  logic [VALUE_W-1:0] timer_value,
  output logic               one_hz_enable,
  output logic               timer_expired,
  output logic [VALUE_W-1:0] time_left,
  output logic               busy
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [VALUE_W-1:0] count_q, count_d;
  logic               tick;

  // The strobe is decoded straight from the prescaler register, so it is
  // glitch-free and low during reset (pre_cnt is 0 and TICK_DIV >= 2).
  assign tick = (pre_cnt_q == PRE_MAX);

  always_comb begin
    // A load restarts the prescaler so the first second is exact.
    if (start_timer || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end

    state_d = state_q;
    count_d = count_q;

    if (start_timer) begin
      count_d = timer_value;
      state_d = (timer_value == '0) ? EXPIRE : COUNT;
    end else begin
      case (state_q)
        COUNT: begin
          // count is never 0 in COUNT; the guard keeps it from wrapping.
          if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
            if (count_q == VALUE_W'(1)) begin
              state_d = EXPIRE;
            end
          end
        end
        EXPIRE: begin
          state_d = IDLE;
          count_d = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      count_q   <= count_d;
    end
  end

  assign one_hz_enable = tick;
  assign timer_expired = (state_q == EXPIRE);
  assign busy          = (state_q == COUNT);
  assign time_left     = count_q;

endmodule

// File: tb/tb_anti_theft_timer.sv
// ---------------------------------------------------------------------------
// tb_anti_theft_timer
//
// Bench for anti_theft_timer with TICK_DIV=10, VALUE_W=4. A reference model
// keeps only "edges since the last load or reset release" plus the loaded
// value, and derives every output arithmetically from those each cycle.
// ---------------------------------------------------------------------------
module tb_anti_theft_timer;

  localparam int TICK = 10;
  localparam int W    = 4;

  logic         clk;
  logic         rst;
  logic         start_timer;
  logic [W-1:0] timer_value;
  logic         one_hz_enable;
  logic         timer_expired;
  logic [W-1:0] time_left;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  anti_theft_timer #(
    .CLK_FREQ_HZ(TICK),
    .TICK_DIV   (TICK),
    .VALUE_W    (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_timer  (start_timer),
    .timer_value  (timer_value),
    .one_hz_enable(one_hz_enable),
    .timer_expired(timer_expired),
    .time_left    (time_left),
    .busy         (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int since_m;   // edges since last load / reset release
  bit active_m;  // a load has happened since reset
  int n_m;       // last loaded value

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      since_m  <= 0;
      active_m <= 1'b0;
      n_m      <= 0;
    end else if (start_timer) begin
      since_m  <= 0;
      active_m <= 1'b1;
      n_m      <= int'(timer_value);
    end else if (since_m < 1000000) begin
      since_m  <= since_m + 1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    int e_one, e_exp, e_busy, e_tl, span;
    e_one  = (since_m % TICK == TICK - 1) ? 1 : 0;
    e_exp  = 0;
    e_busy = 0;
    e_tl   = 0;
    if (active_m) begin
      span = n_m * TICK;
      e_exp  = (since_m == span) ? 1 : 0;
      e_busy = (since_m < span) ? 1 : 0;
      e_tl   = (since_m <= span) ? (n_m - since_m / TICK) : 0;
    end
    check("model_one_hz",  int'(one_hz_enable), e_one);
    check("model_expired", int'(timer_expired), e_exp);
    check("model_busy",    int'(busy),          e_busy);
    check("model_time_left", int'(time_left),   e_tl);
  endtask

  // Drive inputs (we sit at a negedge), take one rising edge, sample at the
  // following negedge and compare against the model.
  task automatic cyc(input logic s, input logic [W-1:0] v);
    start_timer = s;
    timer_value = v;
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  // Load v, then idle for up to budget cycles. delay is the number of edges
  // from the load edge to the first expiry pulse (-1 if none).
  task automatic start_and_measure(input logic [W-1:0] v, input int budget,
                                   output int delay, output int pulses);
    delay  = -1;
    pulses = 0;
    cyc(1'b1, v);
    if (timer_expired) begin
      delay  = 0;
      pulses = 1;
    end
    for (int i = 0; i < budget; i++) begin
      cyc(1'b0, W'($urandom_range(0, 15)));
      if (timer_expired) begin
        if (delay < 0) delay = i + 1;
        pulses++;
      end
    end
  endtask

  // Idle until time_left==tl (and optionally one_hz_enable), bounded.
  task automatic wait_for_tl(input int tl, input bit need_tick, input int budget,
                             output int pulses);
    bit hit;
    hit    = 1'b0;
    pulses = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cyc(1'b0, '0);
      if (timer_expired) pulses++;
      if (int'(time_left) == tl && (!need_tick || one_hz_enable)) hit = 1'b1;
    end
    check("wait_for_time_left_reached", int'(hit), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] val;
    int           exp_delay;
    int           exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d, p, p0, first, second;

    vecs[0] = '{val: 4'd6,  exp_delay: 60,  exp_busy: 1};
    vecs[1] = '{val: 4'd0,  exp_delay: 0,   exp_busy: 0};
    vecs[2] = '{val: 4'd1,  exp_delay: 10,  exp_busy: 1};
    vecs[3] = '{val: 4'd15, exp_delay: 150, exp_busy: 1};
    vecs[4] = '{val: 4'd9,  exp_delay: 90,  exp_busy: 1};
    vecs[5] = '{val: 4'd2,  exp_delay: 20,  exp_busy: 1};

    // ---- reset ----
    rst = 1'b0;
    start_timer = 1'b0;
    timer_value = '0;
    repeat (2) @(negedge clk);
    check("reset_one_hz",    int'(one_hz_enable), 0);
    check("reset_expired",   int'(timer_expired), 0);
    check("reset_busy",      int'(busy),          0);
    check("reset_time_left", int'(time_left),     0);
    rst = 1'b1;
    first  = -1;
    second = -1;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, '0);
      if (one_hz_enable) begin
        if (first < 0) first = i + 1;
        else if (second < 0) second = i + 1;
      end
    end
    check("first_one_hz_edge",  first,  9);
    check("second_one_hz_edge", second, 19);

    // ---- table-driven loads ----
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, vecs[k].val);
      check("tbl_busy_after_load", int'(busy), vecs[k].exp_busy);
      check("tbl_tl_after_load",   int'(time_left),
            (vecs[k].exp_busy != 0) ? int'(vecs[k].val) : 0);
      d = (timer_expired) ? 0 : -1;
      p = (timer_expired) ? 1 : 0;
      for (int i = 0; i < 170; i++) begin
        cyc(1'b0, '0);
        if (timer_expired) begin
          if (d < 0) d = i + 1;
          p++;
        end
      end
      check("tbl_expire_delay", d, vecs[k].exp_delay);
      check("tbl_pulse_count",  p, 1);
      check("tbl_idle_busy",    int'(busy), 0);
      check("tbl_idle_tl",      int'(time_left), 0);
    end

    // ---- re-start mid-count ----
    cyc(1'b1, 4'd8);
    wait_for_tl(3, 1'b0, 100, p0);
    start_and_measure(4'd5, 70, d, p);
    check("restart_old_pulses", p0, 0);
    check("restart_delay",      d, 50);
    check("restart_pulses",     p, 1);

    // ---- start coincident with the final tick ----
    cyc(1'b1, 4'd2);
    wait_for_tl(1, 1'b1, 40, p0);
    start_and_measure(4'd4, 60, d, p);
    check("collide_old_pulses", p0, 0);
    check("collide_delay",      d, 40);
    check("collide_pulses",     p, 1);

    // ---- start during EXPIRE ----
    cyc(1'b1, 4'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0);
    check("expire_seen", int'(timer_expired), 1);
    start_and_measure(4'd3, 40, d, p);
    check("expire_restart_busy", int'(busy), 0);
    check("expire_restart_delay", d, 30);

    // ---- reset mid-count ----
    cyc(1'b1, 4'd12);
    wait_for_tl(7, 1'b0, 80, p0);
    rst = 1'b0;
    #1;
    check("abort_one_hz",    int'(one_hz_enable), 0);
    check("abort_expired",   int'(timer_expired), 0);
    check("abort_busy",      int'(busy),          0);
    check("abort_time_left", int'(time_left),     0);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    first = -1;
    p = 0;
    for (int i = 0; i < 150; i++) begin
      cyc(1'b0, '0);
      if (timer_expired) p++;
      if (one_hz_enable && first < 0) first = i + 1;
    end
    check("abort_no_pulse",   p, 0);
    check("abort_first_tick", first, 9);

    // ---- randomized stimulus against the model ----
    for (int i = 0; i < 2000; i++) begin
      logic         s;
      logic [W-1:0] v;
      s = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3))
                                      : W'($urandom_range(0, 15));
      cyc(s, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
